// File: rtl/disp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | disp_pkg : segment codes and widths for the 7-segment display path       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package disp_pkg;

    localparam int SEG_W = 7;
    localparam int BCD_W = 4;

    // Segment codes, bit 6 down to bit 0; DIGI_X is the all-off (blank) code
    localparam logic [SEG_W-1:0] DIGI_0 = 7'b0111111;
    localparam logic [SEG_W-1:0] DIGI_1 = 7'b0011000;
    localparam logic [SEG_W-1:0] DIGI_2 = 7'b1110110;
    localparam logic [SEG_W-1:0] DIGI_3 = 7'b1111100;
    localparam logic [SEG_W-1:0] DIGI_4 = 7'b1011001;
    localparam logic [SEG_W-1:0] DIGI_5 = 7'b1101101;
    localparam logic [SEG_W-1:0] DIGI_6 = 7'b1101111;
    localparam logic [SEG_W-1:0] DIGI_7 = 7'b0111000;
    localparam logic [SEG_W-1:0] DIGI_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] DIGI_9 = 7'b1111101;
    localparam logic [SEG_W-1:0] DIGI_X = 7'b0000000;

    typedef enum logic [0:0] {
        S_TRACK  = 1'b0,
        S_ACCEPT = 1'b1
    } dec_state_t;

endpackage
`default_nettype wire

// File: rtl/disp_decoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | disp_decoder_if : segment bus in, decoded digit and status out           |
// | Optional member err_count exists with DISP_DECODER_ERRCNT_EN. Rev 1.0    |
// +--------------------------------------------------------------------------+
interface disp_decoder_if;
    import disp_pkg::*;

    logic [SEG_W-1:0] digi;
    logic [BCD_W-1:0] bcd;
    logic             blank;
    logic             err;
    logic             bcd_valid;
`ifdef DISP_DECODER_ERRCNT_EN
    logic [7:0]       err_count;
`endif

`ifdef DISP_DECODER_ERRCNT_EN
    modport master (output digi, input bcd, input blank, input err, input bcd_valid, input err_count);
    modport slave  (input digi, output bcd, output blank, output err, output bcd_valid, output err_count);
`else
    modport master (output digi, input bcd, input blank, input err, input bcd_valid);
    modport slave  (input digi, output bcd, output blank, output err, output bcd_valid);
`endif

endinterface
`default_nettype wire

// File: rtl/disp_seg_lut.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | disp_seg_lut : combinational 7-segment pattern to BCD classifier         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module disp_seg_lut
    import disp_pkg::*;
(
    input  wire logic [SEG_W-1:0] i_seg,
    output logic      [BCD_W-1:0] o_bcd,
    output logic                  o_is_blank,
    output logic                  o_is_err
);

    always_comb begin
        o_bcd      = '0;
        o_is_blank = 1'b0;
        o_is_err   = 1'b0;
        case (i_seg)
            DIGI_0:  o_bcd = 4'd0;
            DIGI_1:  o_bcd = 4'd1;
            DIGI_2:  o_bcd = 4'd2;
            DIGI_3:  o_bcd = 4'd3;
            DIGI_4:  o_bcd = 4'd4;
            DIGI_5:  o_bcd = 4'd5;
            DIGI_6:  o_bcd = 4'd6;
            DIGI_7:  o_bcd = 4'd7;
            DIGI_8:  o_bcd = 4'd8;
            DIGI_9:  o_bcd = 4'd9;
            DIGI_X:  o_is_blank = 1'b1;
            default: o_is_err = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/disp_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | disp_decoder : recovers the BCD digit from a debounced 7-segment bus     |
// | Optional error counter: DISP_DECODER_ERRCNT_EN. Rev 1.0                  |
// +--------------------------------------------------------------------------+
module disp_decoder
    import disp_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
)
(
    input  wire logic     clock,
    input  wire logic     rst_n,
    disp_decoder_if.slave bus
);

    localparam logic [7:0] c_STABLE = 8'(STABLE_CYCLES);

    dec_state_t       r_state;
    dec_state_t       w_state_next;
    logic [SEG_W-1:0] r_samp;
    logic [SEG_W-1:0] r_last;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_next;
    logic             w_accept;

    logic [BCD_W-1:0] r_bcd;
    logic             r_blank;
    logic             r_err;
    logic             r_bcd_valid;

    logic [BCD_W-1:0] w_lut_bcd;
    logic             w_lut_blank;
    logic             w_lut_err;

    disp_seg_lut u_lut (
        .i_seg      (r_samp),
        .o_bcd      (w_lut_bcd),
        .o_is_blank (w_lut_blank),
        .o_is_err   (w_lut_err)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_TRACK;
            r_samp  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_samp  <= bus.digi;
            r_cnt   <= w_cnt_next;
        end
    end

    // The entry test looks at next-cycle sample/count so that the decode lands
    // exactly STABLE_CYCLES edges after the first capture. ACCEPT always
    // returns to TRACK, keeping bcd_valid pulses apart.
    always_comb begin
        w_cnt_next   = r_cnt;
        w_state_next = r_state;
        w_accept     = 1'b0;
        if (bus.digi != r_samp) begin
            w_cnt_next = 8'd1;
        end else if (r_cnt < c_STABLE) begin
            w_cnt_next = r_cnt + 8'd1;
        end
        case (r_state)
            S_TRACK: begin
                if ((w_cnt_next == c_STABLE) && (bus.digi != r_last)) begin
                    w_state_next = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                w_accept     = 1'b1;
                w_state_next = S_TRACK;
            end
            default: w_state_next = S_TRACK;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= '0;
            r_bcd       <= '0;
            r_blank     <= 1'b1;
            r_err       <= 1'b0;
            r_bcd_valid <= 1'b0;
        end else begin
            r_bcd_valid <= w_accept;
            if (w_accept) begin
                r_last  <= r_samp;
                r_blank <= w_lut_blank;
                r_err   <= w_lut_err;
                if (!w_lut_blank && !w_lut_err) begin
                    r_bcd <= w_lut_bcd;
                end
            end
        end
    end

    assign bus.bcd       = r_bcd;
    assign bus.blank     = r_blank;
    assign bus.err       = r_err;
    assign bus.bcd_valid = r_bcd_valid;

`ifdef DISP_DECODER_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_accept && w_lut_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign bus.err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_disp_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_disp_decoder : directed self-checking bench for disp_decoder          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_disp_decoder;

    logic clock = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [6:0] seg_tab [10];

    always #5 clock = ~clock;

    disp_decoder_if bus ();
    disp_decoder_if bus1 ();

    disp_decoder #(.STABLE_CYCLES(4)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    disp_decoder #(.STABLE_CYCLES(1)) dut1 (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_bcd,
                           input logic e_blank, input logic e_err);
        chk({tag, ".bcd"},   8'(bus.bcd),   8'(e_bcd));
        chk({tag, ".blank"}, 8'(bus.blank), 8'(e_blank));
        chk({tag, ".err"},   8'(bus.err),   8'(e_err));
    endtask

    // Hold a pattern for n edges; bcd_valid must be high only after edge pulse_at
    task automatic hold(input logic [6:0] pat, input int n, input int pulse_at);
        bus.digi = pat;
        for (int k = 0; k < n; k++) begin
            @(posedge clock); #1;
            chk("bcd_valid", 8'(bus.bcd_valid), 8'(k == pulse_at));
        end
    endtask

    task automatic hold1(input logic [6:0] pat, input int n, input int pulse_at);
        bus1.digi = pat;
        for (int k = 0; k < n; k++) begin
            @(posedge clock); #1;
            chk("s1.bcd_valid", 8'(bus1.bcd_valid), 8'(k == pulse_at));
        end
    endtask

    initial begin
        seg_tab[0] = 7'b0111111; seg_tab[1] = 7'b0011000;
        seg_tab[2] = 7'b1110110; seg_tab[3] = 7'b1111100;
        seg_tab[4] = 7'b1011001; seg_tab[5] = 7'b1101101;
        seg_tab[6] = 7'b1101111; seg_tab[7] = 7'b0111000;
        seg_tab[8] = 7'b1111111; seg_tab[9] = 7'b1111101;

        rst_n     = 1'b0;
        bus.digi  = 7'b0000000;
        bus1.digi = 7'b0000000;
        repeat (3) @(posedge clock);
        #1;
        chk_out("reset", 4'd0, 1'b1, 1'b0);
        chk("reset.bcd_valid", 8'(bus.bcd_valid), 8'd0);
`ifdef DISP_DECODER_ERRCNT_EN
        chk("reset.err_count", bus.err_count, 8'd0);
`endif
        rst_n = 1'b1;

        // Blank equals the reset last-accepted pattern: no pulse
        hold(7'b0000000, 10, -1);
        chk_out("blank_idle", 4'd0, 1'b1, 1'b0);

        hold(7'b1111100, 6, 4);
        chk_out("digit3", 4'd3, 1'b0, 1'b0);

        // Short-lived 6 is never accepted; the 8 is
        hold(7'b1101111, 3, -1);
        hold(7'b1111111, 6, 4);
        chk_out("digit8", 4'd8, 1'b0, 1'b0);

        for (int d = 0; d < 10; d++) begin
            hold(seg_tab[d], 5, 4);
            chk_out("sweep", 4'(d), 1'b0, 1'b0);
        end

        // Illegal pattern keeps bcd=9
        hold(7'b1000000, 5, 4);
        chk_out("illegal", 4'd9, 1'b0, 1'b1);
`ifdef DISP_DECODER_ERRCNT_EN
        chk("err_count.first", bus.err_count, 8'd1);
`endif

        hold(7'b0000000, 5, 4);
        chk_out("blank_acc", 4'd9, 1'b1, 1'b0);

        // Glitch of 2 cycles back to the accepted pattern: no re-accept
        hold(7'b1101101, 5, 4);
        chk_out("digit5", 4'd5, 1'b0, 1'b0);
        hold(7'b1111111, 2, -1);
        hold(7'b1101101, 6, -1);
        chk_out("glitch", 4'd5, 1'b0, 1'b0);

`ifdef DISP_DECODER_ERRCNT_EN
        for (int i = 0; i < 300; i++) begin
            hold(7'b1000000, 5, 4);
            hold(seg_tab[i % 10], 5, 4);
        end
        chk("err_count.sat", bus.err_count, 8'd255);
        hold(7'b1000000, 5, 4);
        chk("err_count.hold", bus.err_count, 8'd255);
        hold(7'b1101101, 5, 4);
`endif

        // Reset in the middle of counting a new pattern
        hold(7'b0011000, 2, -1);
        rst_n = 1'b0;
        #1;
        chk_out("midreset", 4'd0, 1'b1, 1'b0);
        chk("midreset.bcd_valid", 8'(bus.bcd_valid), 8'd0);
`ifdef DISP_DECODER_ERRCNT_EN
        chk("midreset.err_count", bus.err_count, 8'd0);
`endif
        @(posedge clock); #1;
        chk("midreset.hold_valid", 8'(bus.bcd_valid), 8'd0);
        rst_n = 1'b1;
        hold(7'b0011000, 6, 4);
        chk_out("after_reset", 4'd1, 1'b0, 1'b0);

        // STABLE_CYCLES=1: accepted one edge after capture
        hold1(7'b1110110, 3, 1);
        chk("s1.bcd2", 8'(bus1.bcd), 8'd2);
        hold1(7'b0111000, 3, 1);
        chk("s1.bcd7", 8'(bus1.bcd), 8'd7);
        chk("s1.err", 8'(bus1.err), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
